// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the writeback port arbiter.
// State encoding, requester IDs and statistics counter sizing live here so the
// arbiter and its helpers agree on them.
package wb_arb_pkg;

    // Arbiter ownership state.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_e;

    // Requester IDs double as the mux select value for that requester.
    localparam logic REQ_ALU  = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

    // Statistics counters (only present when WB_ARB_STATS_EN is defined).
    localparam int unsigned STATS_WIDTH = 16;
    localparam logic [STATS_WIDTH-1:0] STATS_MAX = '1;

    // Ownership state for a given requester ID.
    function automatic arb_state_e owner_state(input logic id);
        return (id == REQ_LOAD) ? OWN1 : OWN0;
    endfunction

    // Saturating increment used by the statistics counters.
    function automatic logic [STATS_WIDTH-1:0] stat_next(input logic [STATS_WIDTH-1:0] value,
                                                         input logic hit);
        if (hit && (value != STATS_MAX)) begin
            return value + 1'b1;
        end
        return value;
    endfunction

endpackage

// File: rtl/wb_arb_burst_counter.sv
// Burst length counter for the writeback arbiter.
// Loadable to 1, clearable, and saturating at MAX_COUNT on increment.
// Priority when several controls are asserted: clear, load, increment.
module wb_arb_burst_counter #(
    parameter int unsigned COUNT_WIDTH = 4,
    parameter int unsigned MAX_COUNT   = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   load,
    input  logic                   incr,
    output logic [COUNT_WIDTH-1:0] count
);

    localparam logic [COUNT_WIDTH-1:0] MAX_VAL = COUNT_WIDTH'(MAX_COUNT);
    localparam logic [COUNT_WIDTH-1:0] ONE_VAL = COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;

    // Next count: clear wins, then load-to-1, then saturating increment.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = ONE_VAL;
        end else if (incr && (count_q < MAX_VAL)) begin
            count_d = count_q + ONE_VAL;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback register-file port arbiter.
// Two requesters (0 = ALU result, 1 = load data) share one write port. Grants
// are combinational; an owner keeps the port for up to MAX_BURST back-to-back
// transfers while the other side waits, then ownership flips.
// select drives the writeback 2:1 muxes and parks on the last owner when idle
// so the mux does not toggle.
// Optional build macro WB_ARB_STATS_EN adds conflict_count and stall_count.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST   = 4,
    parameter int unsigned COUNT_WIDTH = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic req0,
    input  logic req1,
    input  logic port_ready,
    output logic gnt0,
    output logic gnt1,
    output logic select,
    output logic write_en
`ifdef WB_ARB_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0] conflict_count,
    output logic [STATS_WIDTH-1:0] stall_count
`endif
);

    localparam logic [COUNT_WIDTH-1:0] MAX_CNT = COUNT_WIDTH'(MAX_BURST);

    arb_state_e             state_q;
    arb_state_e             state_d;
    logic                   last_owner_q;
    logic                   last_owner_d;
    logic [COUNT_WIDTH-1:0] burst_count;
    logic                   below_max;
    logic                   cnt_clear;
    logic                   cnt_load;
    logic                   cnt_incr;
    logic                   grant0;
    logic                   grant1;

    assign below_max = (burst_count < MAX_CNT);

    wb_arb_burst_counter #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .MAX_COUNT   (MAX_BURST)
    ) u_burst_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .load    (cnt_load),
        .incr    (cnt_incr),
        .count   (burst_count)
    );

    // Ownership state and last owner registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_owner_q <= REQ_ALU;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Grant decision and next ownership; everything holds while port_ready is low.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        grant0       = 1'b0;
        grant1       = 1'b0;
        cnt_clear    = 1'b0;
        cnt_load     = 1'b0;
        cnt_incr     = 1'b0;

        if (port_ready) begin
            unique case (state_q)
                IDLE: begin
                    if (req0 && req1) begin
                        // Contention from idle: favour whoever did not own last.
                        if (last_owner_q == REQ_ALU) begin
                            grant1 = 1'b1;
                        end else begin
                            grant0 = 1'b1;
                        end
                    end else begin
                        grant0 = req0;
                        grant1 = req1;
                    end
                    if (grant0 || grant1) begin
                        cnt_load     = 1'b1;
                        last_owner_d = grant1 ? REQ_LOAD : REQ_ALU;
                        state_d      = owner_state(grant1 ? REQ_LOAD : REQ_ALU);
                    end
                end

                OWN0: begin
                    if (req0 && (below_max || !req1)) begin
                        grant0   = 1'b1;
                        cnt_incr = 1'b1;
                    end else if (req1) begin
                        grant1       = 1'b1;
                        cnt_load     = 1'b1;
                        last_owner_d = REQ_LOAD;
                        state_d      = owner_state(REQ_LOAD);
                    end else begin
                        cnt_clear = 1'b1;
                        state_d   = IDLE;
                    end
                end

                OWN1: begin
                    if (req1 && (below_max || !req0)) begin
                        grant1   = 1'b1;
                        cnt_incr = 1'b1;
                    end else if (req0) begin
                        grant0       = 1'b1;
                        cnt_load     = 1'b1;
                        last_owner_d = REQ_ALU;
                        state_d      = owner_state(REQ_ALU);
                    end else begin
                        cnt_clear = 1'b1;
                        state_d   = IDLE;
                    end
                end

                default: begin
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
                end
            endcase
        end
    end

    // Outputs are forced quiet while reset is asserted, independent of the clock.
    assign gnt0     = grant0 & reset_n;
    assign gnt1     = grant1 & reset_n;
    assign write_en = gnt0 | gnt1;
    assign select   = reset_n & (grant1 | (~grant0 & last_owner_q));

`ifdef WB_ARB_STATS_EN
    logic [STATS_WIDTH-1:0] conflict_q;
    logic [STATS_WIDTH-1:0] stall_q;
    logic                   conflict_hit;
    logic                   stall_hit;

    assign conflict_hit = req0 & req1 & port_ready;
    assign stall_hit    = (req0 | req1) & ~port_ready;

    // Saturating event counters for contention and stalled requests.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            conflict_q <= '0;
            stall_q    <= '0;
        end else begin
            conflict_q <= stat_next(conflict_q, conflict_hit);
            stall_q    <= stat_next(stall_q, stall_hit);
        end
    end

    assign conflict_count = conflict_q;
    assign stall_count    = stall_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter.
// A behavioural model (owner / last owner / run length as plain integers)
// predicts the grant every cycle; directed sequences add fixed expected patterns
// and randomized traffic covers the rest.
module tb_wb_port_arbiter;

    localparam int MAX_BURST   = 4;
    localparam int COUNT_WIDTH = 4;

    logic clock;
    logic reset_n;
    logic req0;
    logic req1;
    logic port_ready;
    logic gnt0;
    logic gnt1;
    logic select;
    logic write_en;
`ifdef WB_ARB_STATS_EN
    logic [15:0] conflict_count;
    logic [15:0] stall_count;
`endif

    wb_port_arbiter #(
        .MAX_BURST   (MAX_BURST),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0       (req0),
        .req1       (req1),
        .port_ready (port_ready),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .select     (select),
        .write_en   (write_en)
`ifdef WB_ARB_STATS_EN
        ,
        .conflict_count (conflict_count),
        .stall_count    (stall_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: owner -1 means nobody owns the port.
    int m_owner;
    int m_last;
    int m_run;
    int m_conf;
    int m_stall;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 0;
        m_run   = 0;
        m_conf  = 0;
        m_stall = 0;
    endtask

    // Which requester the rules say transfers this cycle (-1 = none).
    function automatic int model_pick(input logic r0, input logic r1, input logic rdy);
        int r[2];
        int o;
        r[0] = int'(r0);
        r[1] = int'(r1);
        if (!rdy) return -1;
        if (m_owner < 0) begin
            if (r0 && r1) return 1 - m_last;
            if (r0) return 0;
            if (r1) return 1;
            return -1;
        end
        o = m_owner;
        if (r[o] != 0 && (m_run < MAX_BURST || r[1-o] == 0)) return o;
        if (r[1-o] != 0) return 1 - o;
        return -1;
    endfunction

    task automatic model_commit(input int pick, input logic r0, input logic r1, input logic rdy);
        if (rdy) begin
            if (pick < 0) begin
                m_owner = -1;
                m_run   = 0;
            end else if (pick == m_owner) begin
                m_run = (m_run < MAX_BURST) ? m_run + 1 : MAX_BURST;
            end else begin
                m_owner = pick;
                m_run   = 1;
                m_last  = pick;
            end
        end
        if (r0 && r1 && rdy && m_conf < 65535) m_conf++;
        if ((r0 || r1) && !rdy && m_stall < 65535) m_stall++;
    endtask

    // One clock: drive at negedge, check outputs just after, advance model at posedge.
    task automatic do_cycle(input logic rstn, input logic r0, input logic r1, input logic rdy,
                            output int got_id);
        int pick;
        int exp_sel;
        @(negedge clock);
        reset_n    = rstn;
        req0       = r0;
        req1       = r1;
        port_ready = rdy;
        if (!rstn) model_reset();
        #1;
        pick    = rstn ? model_pick(r0, r1, rdy) : -1;
        exp_sel = (pick >= 0) ? pick : (rstn ? m_last : 0);
        check_eq("gnt0", int'(gnt0), int'(pick == 0));
        check_eq("gnt1", int'(gnt1), int'(pick == 1));
        check_eq("write_en", int'(write_en), int'(pick >= 0));
        check_eq("select", int'(select), exp_sel);
        got_id = gnt1 ? 1 : (gnt0 ? 0 : -1);
        @(posedge clock);
        if (rstn) model_commit(pick, r0, r1, rdy);
    endtask

    int got;
    int pat[16];
    logic p0;
    logic p1;
    int prob_req;
    int prob_rdy;
    int hold_mode;

    initial begin
        reset_n    = 1'b0;
        req0       = 1'b1;
        req1       = 1'b1;
        port_ready = 1'b1;
        model_reset();
        pat = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

        // Reset with everything requesting: outputs quiet.
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, 1'b1, 1'b1, 1'b1, got);
            check_eq("reset_quiet", got, -1);
        end

        // Contention right out of reset: requester 1 first, bursts of MAX_BURST.
        for (int i = 0; i < 16; i++) begin
            do_cycle(1'b1, 1'b1, 1'b1, 1'b1, got);
            check_eq("contention", got, pat[i]);
        end

        // Solo burst has no forced switch; the saturated count hands over at once.
        do_cycle(1'b0, 1'b0, 1'b0, 1'b1, got);
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b1, 1'b1, 1'b0, 1'b1, got);
            check_eq("solo", got, 0);
        end
        do_cycle(1'b1, 1'b1, 1'b1, 1'b1, got);
        check_eq("solo_switch", got, 1);

        // Stall mid-burst with count at 2: holds, then two more before switching.
        do_cycle(1'b0, 1'b0, 1'b0, 1'b1, got);
        do_cycle(1'b1, 1'b1, 1'b0, 1'b1, got);
        do_cycle(1'b1, 1'b1, 1'b0, 1'b1, got);
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, 1'b1, 1'b1, 1'b0, got);
            check_eq("stall_none", got, -1);
            check_eq("stall_select", int'(select), 0);
        end
        do_cycle(1'b1, 1'b1, 1'b1, 1'b1, got);
        check_eq("stall_resume0", got, 0);
        do_cycle(1'b1, 1'b1, 1'b1, 1'b1, got);
        check_eq("stall_resume1", got, 0);
        do_cycle(1'b1, 1'b1, 1'b1, 1'b1, got);
        check_eq("stall_switch", got, 1);

        // Owner drops its request: switch in the same cycle, then go idle.
        do_cycle(1'b0, 1'b0, 1'b0, 1'b1, got);
        do_cycle(1'b1, 1'b0, 1'b1, 1'b1, got);
        check_eq("drop_own1", got, 1);
        do_cycle(1'b1, 1'b1, 1'b0, 1'b1, got);
        check_eq("drop_switch", got, 0);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b1, got);
        check_eq("drop_idle", got, -1);
        check_eq("drop_idle_select", int'(select), 0);
        do_cycle(1'b1, 1'b1, 1'b1, 1'b1, got);
        check_eq("idle_pref1", got, 1);

        // Reset in the middle of a burst aborts it; requester 1 preferred after.
        do_cycle(1'b1, 1'b1, 1'b1, 1'b1, got);
        do_cycle(1'b0, 1'b1, 1'b1, 1'b1, got);
        check_eq("midreset_quiet", got, -1);
        do_cycle(1'b1, 1'b1, 1'b1, 1'b1, got);
        check_eq("midreset_restart", got, 1);

        // Randomized traffic in phases of varying request/ready density.
        p0 = 1'b0;
        p1 = 1'b0;
        prob_req  = 50;
        prob_rdy  = 70;
        hold_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                prob_req  = $urandom_range(95, 10);
                prob_rdy  = $urandom_range(100, 30);
                hold_mode = $urandom_range(1, 0);
            end
            // In hold mode a request stays up until granted, as real requesters do.
            if (!(hold_mode != 0 && p0)) p0 = ($urandom_range(99, 0) < prob_req);
            if (!(hold_mode != 0 && p1)) p1 = ($urandom_range(99, 0) < prob_req);
            if ($urandom_range(499, 0) == 0) begin
                do_cycle(1'b0, p0, p1, 1'b1, got);
            end else begin
                do_cycle(1'b1, p0, p1, ($urandom_range(99, 0) < prob_rdy), got);
                if (got == 0) p0 = 1'b0;
                if (got == 1) p1 = 1'b0;
            end
        end

`ifdef WB_ARB_STATS_EN
        // Statistics: 5 contention cycles and 3 stalled requesting cycles.
        do_cycle(1'b0, 1'b0, 1'b0, 1'b1, got);
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b1, 1'b1, 1'b1, got);
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b1, 1'b0, 1'b0, got);
        #1;
        check_eq("conflict_count", int'(conflict_count), 5);
        check_eq("stall_count", int'(stall_count), 3);
        check_eq("conflict_model", int'(conflict_count), m_conf);
        @(negedge clock);
        force dut.conflict_q = 16'hFFFF;
        force dut.stall_q    = 16'hFFFF;
        @(posedge clock);
        #1;
        release dut.conflict_q;
        release dut.stall_q;
        m_conf  = 65535;
        m_stall = 65535;
        do_cycle(1'b1, 1'b1, 1'b1, 1'b1, got);
        do_cycle(1'b1, 1'b1, 1'b1, 1'b0, got);
        #1;
        check_eq("conflict_sat", int'(conflict_count), 65535);
        check_eq("stall_sat", int'(stall_count), 65535);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between two writeback requesters: requester 0 (ALU result) and requester 1 (load data).
- Drives the select line of the writeback-stage 2:1 muxes for data, destination register and write-enable, plus per-requester grants.
- Round-robin with bounded bursts: an owner may keep the port for up to MAX_BURST consecutive transfers while the other requester waits.

Parameters:
- MAX_BURST, 4, maximum consecutive grants to one owner while the other requester is requesting; legal range 1..15.
- COUNT_WIDTH, 4, burst counter width; must hold MAX_BURST.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 has a result to write; held high until granted.
- req1  input  1  requester 1 has a result to write; held high until granted.
- port_ready  input  1  write port may accept a write this cycle; low = pipeline stall.
- gnt0  output  1  requester 0 transfers this cycle (combinational).
- gnt1  output  1  requester 1 transfers this cycle (combinational).
- select  output  1  mux select: 1 = requester 1 path, 0 = requester 0 path.
- write_en  output  1  equals gnt0 | gnt1.

Behaviour:
- State register: IDLE, OWN0, OWN1. Also last_owner (1 bit) and burst_count (COUNT_WIDTH bits).
- Reset (reset_n low, asynchronous): state = IDLE, last_owner = 0, burst_count = 0. gnt0, gnt1 and write_en are forced to 0 and select to 0 while reset_n is low.
- A transfer occurs in a cycle when its grant is high. Grants are combinational from the current state and inputs; there is no added latency. gnt0 and gnt1 are never both high.
- port_ready low:
  - No grant is issued and write_en = 0.
  - State, last_owner and burst_count hold.
  - select holds last_owner.
- port_ready high, state IDLE:
  - Both requesting: grant the requester that is not last_owner.
  - One requesting: grant that requester.
  - The granted requester becomes the owner: state -> OWNx, burst_count = 1, last_owner = x.
  - None requesting: stay IDLE.
- port_ready high, state OWNx:
  - If reqx = 1 and (burst_count < MAX_BURST or the other requester is not requesting): grant x again. burst_count increments, saturating at MAX_BURST.
  - Else if the other requester is requesting: grant the other requester, switching in the same cycle. state -> OWN(other), burst_count = 1, last_owner = other.
  - Else (no requests): state -> IDLE, burst_count = 0; last_owner is kept.
- select = 1 when gnt1, 0 when gnt0, and last_owner when there is no grant (prevents mux toggling).
- Fairness: with both requesters continuously requesting, ownership alternates every MAX_BURST grants. Worst-case wait is MAX_BURST ready cycles.
- MAX_BURST = 1 degenerates to strict alternation under contention.
- Requests are not latched. If a requester drops req before it is granted, nothing is recorded for it.
- Reset asserted mid-burst aborts the burst. After release, arbitration restarts from IDLE with requester 1 preferred, because last_owner = 0.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- Defined:
  - Adds output port conflict_count (16 bits): a saturating count of cycles with req0 & req1 & port_ready.
  - Adds output port stall_count (16 bits): a saturating count of cycles with (req0 | req1) & !port_ready.
  - Both counters reset to 0 on reset_n low and saturate at 16'hFFFF.
- Not defined: neither port nor its logic exists. Arbitration behaviour is identical in both builds.

Decomposition:
- Package wb_arb_pkg contains:
  - State encoding constants: IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10.
  - Requester ID constants: REQ_ALU = 1'b0, REQ_LOAD = 1'b1.
  - The stats counter width (16).
- One natural sub-module, wb_arb_burst_counter: a loadable, saturating COUNT_WIDTH counter with load-to-1, clear, increment and hold controls.
- The writeback 2:1 muxes remain in the parent stage and are driven by select.

Test Plan:
- Reset: hold reset_n low with req0 = req1 = 1 and port_ready = 1 → gnt0 = gnt1 = write_en = select = 0. Release → first cycle gnt1 = 1 (last_owner = 0).
- Contention with MAX_BURST = 4, both requesting, port_ready = 1 for 16 cycles → grant pattern 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0 (requester IDs); write_en = 1 every cycle.
- Solo burst: req0 only, for 10 cycles → gnt0 = 1 all 10 cycles with no forced switch. Assert req1 in cycle 11 → gnt1 in cycle 11, because burst_count is saturated at 4.
- Stall: owner OWN0 with burst_count = 2, port_ready = 0 for 3 cycles → no grants, select = 0, burst_count stays 2. Ready returns → 2 more gnt0 before switching to requester 1.
- Owner drops req: OWN1 with req1 falling to 0 while req0 = 1 → gnt0 in the same cycle and state OWN0. Both requests low → IDLE; select holds the last owner.
- WB_ARB_STATS_EN build: 5 contention cycles plus 3 stalled requesting cycles → conflict_count = 5 and stall_count = 3. Check saturation by forcing the counters to 16'hFFFF.
